trap_ctrl: RTL and testbench

//  Machine-mode trap sequencer for the 3-stage RV32 core; sits beside the main decoder.

---
 rtl/trap_ctrl_pkg.sv | 31 +++
 rtl/trap_ctrl_irq_sync.sv | 21 ++
 rtl/trap_ctrl.sv | 168 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_DRAIN = 2'd3
    } trap_state_e;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Pending vector bit positions, matching the mie port order {meie,msie,mtie}.
    localparam int IRQ_EXT   = 2;
    localparam int IRQ_SW    = 1;
    localparam int IRQ_TIMER = 0;

    // Fixed priority ext > sw > timer; only meaningful when pend is non-zero.
    function automatic logic [3:0] irq_cause(input logic [2:0] pend);
        logic [3:0] code;
        if (pend[IRQ_EXT])     code = CAUSE_MEI;
        else if (pend[IRQ_SW]) code = CAUSE_MSI;
        else                   code = CAUSE_MTI;
        return code;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for one asynchronous level interrupt line.
module irq_sync #(
    parameter int STAGES = 2    // must be >= 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw level through the flop chain; cleared by sync reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_chain <= '0;
        else          r_chain <= {r_chain[STAGES-2:0], i_async};
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: interrupt entry and mret return for the 3-stage core.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | watching EX for mret or a pending irq on a real instruction
// ST_TRAP  | redirecting to mtvec; CSR strobes on first cycle, held on stall
// ST_RET   | redirecting to mepc; mstatus restore on first cycle, held on stall
// ST_DRAIN | one extra flush cycle to clear the second pipeline stage
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_irq_ext,
    input  logic          i_irq_sw,
    input  logic          i_irq_timer,
    input  logic          i_mstatus_mie,
    input  logic [2:0]    i_mie,
    input  logic          i_is_mret,
    input  logic          i_ex_valid,
    input  logic [DW-1:0] i_pc_ex,
    input  logic          i_stall_in,
    input  logic [DW-1:0] i_mtvec,
    input  logic [DW-1:0] i_mepc_q,
    output logic          o_ex_kill,
    output logic          o_flush,
    output logic          o_redirect,
    output logic [DW-1:0] o_redirect_pc,
    output logic          o_mepc_we,
    output logic [DW-1:0] o_mepc_wdata,
    output logic          o_mcause_we,
    output logic [DW-1:0] o_mcause_wdata,
    output logic          o_mstatus_trap,
    output logic          o_mstatus_mret,
    output logic          o_busy
);

    localparam logic [DW-1:0] ALIGN4_MASK = {{(DW-2){1'b1}}, 2'b00};

    trap_state_e   r_state;
    trap_state_e   w_state_nxt;
    logic [DW-1:0] r_epc;
    logic [3:0]    r_cause;
    logic          r_done;

    logic [2:0]    w_irq_sync;
    logic [2:0]    w_pending;
    logic          w_capture;
    logic [DW-1:0] w_trap_pc;

    logic          w_ex_kill;
    logic          w_flush;
    logic          w_redirect;
    logic [DW-1:0] w_redirect_pc;
    logic          w_mepc_we;
    logic          w_mcause_we;
    logic [DW-1:0] w_mcause_wdata;
    logic          w_mstatus_trap;
    logic          w_mstatus_mret;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_irq_ext), .o_sync(w_irq_sync[IRQ_EXT])
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_irq_sw), .o_sync(w_irq_sync[IRQ_SW])
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_irq_timer), .o_sync(w_irq_sync[IRQ_TIMER])
    );

    assign w_pending = w_irq_sync & i_mie & {3{i_mstatus_mie}};

    // Vectored mode adds 4*cause to the aligned base; direct mode uses the base alone.
    always_comb begin
        w_trap_pc = i_mtvec & ALIGN4_MASK;
        if (VECTORED_EN && (i_mtvec[1:0] == MTVEC_VECTORED))
            w_trap_pc = w_trap_pc + {{(DW-6){1'b0}}, r_cause, 2'b00};
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Capture the killed instruction's PC and the winning cause on trap entry.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_epc   <= '0;
            r_cause <= '0;
        end else if (w_capture) begin
            r_epc   <= i_pc_ex;
            r_cause <= irq_cause(w_pending);
        end
    end

    // Marks that the one-shot CSR strobes of TRAP/RET have already been issued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_done <= 1'b0;
        else          r_done <= (r_state == ST_TRAP) || (r_state == ST_RET);
    end

    // Next-state and output decode; mret wins over a coincident irq.
    always_comb begin
        w_state_nxt    = r_state;
        w_capture      = 1'b0;
        w_ex_kill      = 1'b0;
        w_flush        = 1'b0;
        w_redirect     = 1'b0;
        w_redirect_pc  = '0;
        w_mepc_we      = 1'b0;
        w_mcause_we    = 1'b0;
        w_mcause_wdata = '0;
        w_mstatus_trap = 1'b0;
        w_mstatus_mret = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_is_mret && i_ex_valid && !i_stall_in) begin
                    w_state_nxt = ST_RET;
                end else if ((|w_pending) && i_ex_valid && !i_stall_in) begin
                    w_ex_kill   = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = ST_TRAP;
                end
            end
            ST_TRAP: begin
                w_flush        = 1'b1;
                w_redirect     = 1'b1;
                w_redirect_pc  = w_trap_pc;
                w_mepc_we      = !r_done;
                w_mcause_we    = !r_done;
                w_mstatus_trap = !r_done;
                w_mcause_wdata = {1'b1, {(DW-5){1'b0}}, r_cause};
                if (!i_stall_in) w_state_nxt = ST_DRAIN;
            end
            ST_RET: begin
                w_flush        = 1'b1;
                w_redirect     = 1'b1;
                w_redirect_pc  = i_mepc_q & ALIGN4_MASK;
                w_mstatus_mret = !r_done;
                if (!i_stall_in) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_flush     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs are forced low while reset is asserted.
    assign o_ex_kill      = w_ex_kill      & i_rst_n;
    assign o_flush        = w_flush        & i_rst_n;
    assign o_redirect     = w_redirect     & i_rst_n;
    assign o_mepc_we      = w_mepc_we      & i_rst_n;
    assign o_mcause_we    = w_mcause_we    & i_rst_n;
    assign o_mstatus_trap = w_mstatus_trap & i_rst_n;
    assign o_mstatus_mret = w_mstatus_mret & i_rst_n;
    assign o_busy         = (r_state != ST_IDLE) & i_rst_n;
    assign o_redirect_pc  = w_redirect_pc  & {DW{i_rst_n}};
    assign o_mcause_wdata = w_mcause_wdata & {DW{i_rst_n}};
    assign o_mepc_wdata   = r_epc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, trap entry, vectoring, mret, stall, gating, reset in TRAP.
module tb_trap_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          irq_ext, irq_sw, irq_timer, mstatus_mie;
    logic [2:0]    mie;
    logic          is_mret, ex_valid, stall_in;
    logic [DW-1:0] pc_ex, mtvec, mepc_q;
    logic          ex_kill, flush, redirect, mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy;
    logic [DW-1:0] redirect_pc, mepc_wdata, mcause_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.DW(DW), .SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_irq_ext(irq_ext), .i_irq_sw(irq_sw), .i_irq_timer(irq_timer),
        .i_mstatus_mie(mstatus_mie), .i_mie(mie),
        .i_is_mret(is_mret), .i_ex_valid(ex_valid), .i_pc_ex(pc_ex),
        .i_stall_in(stall_in), .i_mtvec(mtvec), .i_mepc_q(mepc_q),
        .o_ex_kill(ex_kill), .o_flush(flush), .o_redirect(redirect),
        .o_redirect_pc(redirect_pc), .o_mepc_we(mepc_we), .o_mepc_wdata(mepc_wdata),
        .o_mcause_we(mcause_we), .o_mcause_wdata(mcause_wdata),
        .o_mstatus_trap(mstatus_trap), .o_mstatus_mret(mstatus_mret), .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        irq_ext = 0; irq_sw = 0; irq_timer = 0;
        is_mret = 0; ex_valid = 0; stall_in = 0;
        repeat (4) tick();
    endtask

    // Waits up to 6 cycles for ex_kill; returns at the negedge where it was seen.
    task automatic wait_kill(output bit seen, output int n);
        seen = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n++;
            if (ex_kill === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; irq_timer = 1; irq_ext = 0; irq_sw = 0;
        mie = 3'b111; mstatus_mie = 1; ex_valid = 1; is_mret = 0; stall_in = 0;
        pc_ex = 32'h80; mtvec = 32'h40; mepc_q = 32'h10;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({ex_kill, flush, redirect, mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 00000000",
                     {ex_kill, flush, redirect, mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy});
        end
        checks++;
        if ({redirect_pc, mepc_wdata, mcause_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got pc=%h epc=%h cause=%h exp all 0", redirect_pc, mepc_wdata, mcause_wdata);
        end
        tick();
        rst_n = 1;
        quiesce();
    endtask

    task automatic test_timer_trap();
        bit seen;
        int n;
        mtvec = 32'h400; mie = 3'b001; mstatus_mie = 1; pc_ex = 32'h100;
        ex_valid = 1; irq_timer = 1;
        wait_kill(seen, n);
        checks++;
        if (!seen || n > 3) begin
            errors++;
            $display("FAIL timer_kill_latency: seen=%0d cycles=%0d exp seen within 3", seen, n);
        end
        checks++;
        if (redirect !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timer_kill_cycle: got redirect=%b busy=%b exp 0 0", redirect, busy);
        end
        tick();
        irq_timer = 0; ex_valid = 0;
        @(negedge clk);
        checks++;
        if (redirect_pc !== 32'h400 || redirect !== 1'b1 || flush !== 1'b1) begin
            errors++;
            $display("FAIL timer_redirect: got pc=%h red=%b flush=%b exp 00000400 1 1", redirect_pc, redirect, flush);
        end
        checks++;
        if (mepc_we !== 1'b1 || mepc_wdata !== 32'h100 || mcause_we !== 1'b1 || mcause_wdata !== 32'h80000007) begin
            errors++;
            $display("FAIL timer_csr: got epc_we=%b epc=%h cause_we=%b cause=%h exp 1 00000100 1 80000007",
                     mepc_we, mepc_wdata, mcause_we, mcause_wdata);
        end
        checks++;
        if (mstatus_trap !== 1'b1 || ex_kill !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timer_mstatus: got trap=%b kill=%b busy=%b exp 1 0 1", mstatus_trap, ex_kill, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (flush !== 1'b1 || redirect !== 1'b0 || mepc_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timer_drain: got flush=%b red=%b epc_we=%b busy=%b exp 1 0 0 1", flush, redirect, mepc_we, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timer_idle: got flush=%b busy=%b exp 0 0", flush, busy);
        end
        quiesce();
    endtask

    task automatic test_vectored();
        bit seen;
        int n;
        mtvec = 32'h201; mie = 3'b101; mstatus_mie = 1; pc_ex = 32'h180;
        ex_valid = 1; irq_ext = 1; irq_timer = 1;
        wait_kill(seen, n);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL vec_kill: got no ex_kill in %0d cycles exp kill", n);
        end
        tick();
        irq_ext = 0; irq_timer = 0; ex_valid = 0;
        @(negedge clk);
        checks++;
        if (mcause_wdata !== 32'h8000000B || redirect_pc !== 32'h22C || mepc_wdata !== 32'h180) begin
            errors++;
            $display("FAIL vec_target: got cause=%h pc=%h epc=%h exp 8000000b 0000022c 00000180",
                     mcause_wdata, redirect_pc, mepc_wdata);
        end
        quiesce();
    endtask

    task automatic test_mret();
        int kills = 0;
        mie = 3'b010; mstatus_mie = 1; irq_sw = 1; ex_valid = 0; mepc_q = 32'h107;
        mtvec = 32'h400;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ex_kill === 1'b1 || busy === 1'b1) kills++;
            tick();
        end
        checks++;
        if (kills != 0) begin
            errors++;
            $display("FAIL bubble_no_trap: got %0d kill/busy cycles exp 0", kills);
        end
        is_mret = 1; ex_valid = 1;
        @(negedge clk);
        checks++;
        if (ex_kill !== 1'b0) begin
            errors++;
            $display("FAIL mret_no_kill: got ex_kill=%b exp 0", ex_kill);
        end
        tick();
        is_mret = 0; ex_valid = 0; stall_in = 1;
        @(negedge clk);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h104 || mstatus_mret !== 1'b1 || flush !== 1'b1) begin
            errors++;
            $display("FAIL mret_redirect: got red=%b pc=%h mret=%b flush=%b exp 1 00000104 1 1",
                     redirect, redirect_pc, mstatus_mret, flush);
        end
        checks++;
        if (mstatus_trap !== 1'b0 || mepc_we !== 1'b0 || mcause_we !== 1'b0) begin
            errors++;
            $display("FAIL mret_no_trap_strobes: got trap=%b epc_we=%b cause_we=%b exp 0 0 0",
                     mstatus_trap, mepc_we, mcause_we);
        end
        tick();
        stall_in = 0;
        @(negedge clk);
        checks++;
        if (redirect !== 1'b1 || mstatus_mret !== 1'b0) begin
            errors++;
            $display("FAIL mret_hold_once: got red=%b mret=%b exp 1 0", redirect, mstatus_mret);
        end
        tick();
        @(negedge clk);
        checks++;
        if (flush !== 1'b1 || redirect !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mret_drain: got flush=%b red=%b busy=%b exp 1 0 1", flush, redirect, busy);
        end
        quiesce();
    endtask

    task automatic test_stall_trap();
        bit seen;
        int n;
        int n_red = 0, n_flush = 0, n_epc = 0, n_trap = 0;
        mtvec = 32'h300; mie = 3'b001; mstatus_mie = 1; pc_ex = 32'h200;
        ex_valid = 1; irq_timer = 1;
        wait_kill(seen, n);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_kill: got no ex_kill in %0d cycles exp kill", n);
        end
        tick();
        stall_in = 1; irq_timer = 0; ex_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (redirect === 1'b1)     n_red++;
            if (flush === 1'b1)        n_flush++;
            if (mepc_we === 1'b1)      n_epc++;
            if (mstatus_trap === 1'b1) n_trap++;
            tick();
            if (i == 2) stall_in = 0;
        end
        checks++;
        if (n_red != 4 || n_flush != 5) begin
            errors++;
            $display("FAIL stall_hold: got redirect=%0d flush=%0d cycles exp 4 5", n_red, n_flush);
        end
        checks++;
        if (n_epc != 1 || n_trap != 1) begin
            errors++;
            $display("FAIL stall_one_pulse: got mepc_we=%0d mstatus_trap=%0d pulses exp 1 1", n_epc, n_trap);
        end
        quiesce();
    endtask

    task automatic test_gating();
        int kills = 0;
        mtvec = 32'h500; mie = 3'b010; mstatus_mie = 0; pc_ex = 32'h240;
        ex_valid = 1; irq_sw = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ex_kill === 1'b1 || busy === 1'b1) kills++;
            tick();
        end
        checks++;
        if (kills != 0) begin
            errors++;
            $display("FAIL gmie_no_trap: got %0d kill/busy cycles exp 0", kills);
        end
        mstatus_mie = 1;
        @(negedge clk);
        checks++;
        if (ex_kill !== 1'b1) begin
            errors++;
            $display("FAIL gmie_enable_kill: got ex_kill=%b exp 1", ex_kill);
        end
        tick();
        irq_sw = 0; ex_valid = 0;
        @(negedge clk);
        checks++;
        if (mcause_wdata !== 32'h80000003 || redirect_pc !== 32'h500 || mepc_wdata !== 32'h240) begin
            errors++;
            $display("FAIL gmie_target: got cause=%h pc=%h epc=%h exp 80000003 00000500 00000240",
                     mcause_wdata, redirect_pc, mepc_wdata);
        end
        quiesce();
    endtask

    task automatic test_reset_in_trap();
        bit seen;
        int n;
        mtvec = 32'h600; mie = 3'b001; mstatus_mie = 1; pc_ex = 32'h3C0;
        ex_valid = 1; irq_timer = 1;
        wait_kill(seen, n);
        tick();
        irq_timer = 0; ex_valid = 0; stall_in = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL rst_trap_entered: got busy=%b red=%b exp 1 1", busy, redirect);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({ex_kill, flush, redirect, mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy} !== 8'h00) begin
            errors++;
            $display("FAIL rst_trap_ctrl: got %b exp 00000000",
                     {ex_kill, flush, redirect, mepc_we, mcause_we, mstatus_trap, mstatus_mret, busy});
        end
        checks++;
        if (mepc_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_trap_data: got epc=%h pc=%h exp 0 0", mepc_wdata, redirect_pc);
        end
        quiesce();
    endtask

    initial begin
        test_reset();
        test_timer_trap();
        test_vectored();
        test_mret();
        test_stall_trap();
        test_gating();
        test_reset_in_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
